// File: rtl/pp_stream_sink_if.sv
// Upstream word stream into the ping-pong sink: valid/data from the buffer, ready back to it.
// Ports: data_valid/data driven by the master (buffer), data_ready driven by the slave (sink).
// No logic here, only signal bundling; the sink registers data_ready.
interface pp_stream_sink_if #(
  parameter int DATA_W = 64
);
  logic              data_valid;
  logic [DATA_W-1:0] data;
  logic              data_ready;

  modport master (output data_valid, output data, input data_ready);
  modport slave  (input data_valid, input data, output data_ready);
endinterface

// File: rtl/pp_stream_sink.sv
// Stream sink: accepts words, checks them against an incrementing pattern, and counts frames/errors.
// Latency: o_frame_done and counters update one cycle after the accepting edge.
// Backpressure: ready is a flop, chosen by i_bp_mode and forced low for GAP_CYCLES after each frame.
// Ports: sys_clk/sys_rst_n clock and async reset, i_enable run control, i_clr counter clear,
//        i_bp_mode ready pattern, up_if stream slave, o_frame_* / o_err* statistics.
module pp_stream_sink #(
  parameter int                DATA_W     = 64,
  parameter int                FRAME_LEN  = 64,
  parameter int                GAP_CYCLES = 4,
  parameter logic [DATA_W-1:0] SEED       = '0,
  parameter logic [15:0]       LFSR_INIT  = 16'hACE1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              i_enable,
  input  logic              i_clr,
  input  logic [1:0]        i_bp_mode,
  pp_stream_sink_if.slave   up_if,
  output logic              o_frame_done,
  output logic [15:0]       o_frame_cnt,
  output logic [15:0]       o_err_cnt,
  output logic              o_err,
  output logic [DATA_W-1:0] o_first_err_data
);

  localparam int WIDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WIDX_W-1:0] IDX_LAST = WIDX_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_GAP} state_e;

  state_e             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               ready_q, ready_d;
  logic [15:0]        lfsr_q;
  logic               enter;

  logic [DATA_W-1:0]  expected_q;
  logic [WIDX_W-1:0]  word_idx_q;
  logic               frame_done_q;
  logic [15:0]        frame_cnt_q;
  logic [15:0]        err_cnt_q;
  logic               err_q;
  logic [DATA_W-1:0]  first_err_q;

  logic xfer, last_word, frame_end;

  assign xfer      = up_if.data_valid && ready_q;
  assign last_word = (word_idx_q == IDX_LAST);
  // A word accepted in an i_clr cycle is discarded, so it cannot close a frame either.
  assign frame_end = xfer && !i_clr && last_word && (state_q == S_RECV);

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic; i_enable is only looked at on frame boundaries.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (i_enable) state_d = S_RECV;
      end
      S_RECV: begin
        if (frame_end) begin
          if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
            gap_d   = '0;
          end else begin
            state_d = i_enable ? S_RECV : S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = i_enable ? S_RECV : S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ready is computed for the state we are about to be in, so it is valid the
  // cycle after the decision and never looks at data_valid combinationally.
  always_comb begin
    ready_d = 1'b0;
    enter   = (state_d == S_RECV) && ((state_q != S_RECV) || frame_end);
    if (state_d == S_RECV) begin
      case (i_bp_mode)
        2'd0:    ready_d = 1'b1;
        2'd1:    ready_d = enter ? 1'b1 : ~ready_q;
        2'd2:    ready_d = lfsr_q[0];
        default: ready_d = 1'b0;
      endcase
    end
  end

  // x^16+x^14+x^13+x^11+1 Fibonacci LFSR, only stepping while receiving.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lfsr_q <= LFSR_INIT;
    end else if (state_q == S_RECV) begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  // Pattern checker and statistics. The expected value advances on every
  // accepted word, including mismatches, so one bad word costs one error.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      expected_q   <= SEED;
      word_idx_q   <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_cnt_q    <= '0;
      err_q        <= 1'b0;
      first_err_q  <= '0;
    end else begin
      frame_done_q <= frame_end;
      if (i_clr) begin
        expected_q  <= SEED;
        word_idx_q  <= '0;
        frame_cnt_q <= '0;
        err_cnt_q   <= '0;
        err_q       <= 1'b0;
        first_err_q <= '0;
      end else if (xfer) begin
        expected_q <= expected_q + DATA_W'(1);
        word_idx_q <= last_word ? '0 : word_idx_q + WIDX_W'(1);
        if (up_if.data != expected_q) begin
          if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
          if (!err_q) begin
            err_q       <= 1'b1;
            first_err_q <= up_if.data;
          end
        end
        if (last_word && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign up_if.data_ready = ready_q;
  assign o_frame_done     = frame_done_q;
  assign o_frame_cnt      = frame_cnt_q;
  assign o_err_cnt        = err_cnt_q;
  assign o_err            = err_q;
  assign o_first_err_data = first_err_q;

endmodule
